// File: rtl/exe_cond_stage.sv
// Execute-stage condition check, architectural NZCV flag register and the E->M pipeline register.
// Controls with side effects are squashed when the condition fails; flush zeroes the M stage.
module exe_cond_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallM,
    input  logic         FlushM,
    input  logic [3:0]   CondE,
    input  logic [1:0]   FlagWriteE,
    input  logic [3:0]   AluFlags,
    input  logic [N-1:0] ALUResultE,
    input  logic [N-1:0] WriteDataE,
    input  logic [3:0]   WA3E,
    input  logic         PCSrcE,
    input  logic         RegWriteE,
    input  logic         MemWriteE,
    input  logic         MemtoRegE,
    input  logic         BranchE,
    output logic [3:0]   Flags,
    output logic         CondExE,
    output logic         BranchTakenE,
    output logic         PCSrcM,
    output logic         RegWriteM,
    output logic         MemWriteM,
    output logic         MemtoRegM,
    output logic [N-1:0] ALUResultM,
    output logic [N-1:0] WriteDataM,
    output logic [3:0]   WA3M
);

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_t;

    logic [3:0]   r_flags;
    logic         r_pcSrcM;
    logic         r_regWriteM;
    logic         r_memWriteM;
    logic         r_memtoRegM;
    logic [N-1:0] r_aluResultM;
    logic [N-1:0] r_writeDataM;
    logic [3:0]   r_wa3M;

    logic w_n, w_z, w_c, w_v;
    logic w_condEx;
    logic w_flagWrNZ;
    logic w_flagWrCV;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition is judged only against the registered flags, so a flag-setting
    // instruction influences the next instruction, never itself.
    always_comb begin
        w_condEx = 1'b0;
        case (cond_t'(CondE))
            EQ: w_condEx = w_z;
            NE: w_condEx = ~w_z;
            CS: w_condEx = w_c;
            CC: w_condEx = ~w_c;
            MI: w_condEx = w_n;
            PL: w_condEx = ~w_n;
            VS: w_condEx = w_v;
            VC: w_condEx = ~w_v;
            HI: w_condEx = w_c & ~w_z;
            LS: w_condEx = ~w_c | w_z;
            GE: w_condEx = (w_n == w_v);
            LT: w_condEx = (w_n != w_v);
            GT: w_condEx = ~w_z & (w_n == w_v);
            LE: w_condEx = w_z | (w_n != w_v);
            AL: w_condEx = 1'b1;
            NV: w_condEx = 1'b0;
            default: w_condEx = 1'b0;
        endcase
    end

    assign w_flagWrNZ = FlagWriteE[1] & w_condEx;
    assign w_flagWrCV = FlagWriteE[0] & w_condEx;

    // Reset beats flush beats stall; flags only move on a normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags      <= 4'b0000;
            r_pcSrcM     <= 1'b0;
            r_regWriteM  <= 1'b0;
            r_memWriteM  <= 1'b0;
            r_memtoRegM  <= 1'b0;
            r_aluResultM <= '0;
            r_writeDataM <= '0;
            r_wa3M       <= 4'b0000;
        end else if (FlushM) begin
            r_pcSrcM     <= 1'b0;
            r_regWriteM  <= 1'b0;
            r_memWriteM  <= 1'b0;
            r_memtoRegM  <= 1'b0;
            r_aluResultM <= '0;
            r_writeDataM <= '0;
            r_wa3M       <= 4'b0000;
        end else if (!StallM) begin
            r_pcSrcM     <= PCSrcE & w_condEx;
            r_regWriteM  <= RegWriteE & w_condEx;
            r_memWriteM  <= MemWriteE & w_condEx;
            r_memtoRegM  <= MemtoRegE;
            r_aluResultM <= ALUResultE;
            r_writeDataM <= WriteDataE;
            r_wa3M       <= WA3E;
            if (w_flagWrNZ) begin
                r_flags[3:2] <= AluFlags[3:2];
            end
            if (w_flagWrCV) begin
                r_flags[1:0] <= AluFlags[1:0];
            end
        end
    end

    assign Flags        = r_flags;
    assign CondExE      = w_condEx;
    assign BranchTakenE = BranchE & w_condEx;
    assign PCSrcM       = r_pcSrcM;
    assign RegWriteM    = r_regWriteM;
    assign MemWriteM    = r_memWriteM;
    assign MemtoRegM    = r_memtoRegM;
    assign ALUResultM   = r_aluResultM;
    assign WriteDataM   = r_writeDataM;
    assign WA3M         = r_wa3M;

endmodule

// File: tb/tb_exe_cond_stage.sv
// Bench for exe_cond_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_exe_cond_stage;

    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic         StallM, FlushM;
    logic [3:0]   CondE;
    logic [1:0]   FlagWriteE;
    logic [3:0]   AluFlags;
    logic [N-1:0] ALUResultE, WriteDataE;
    logic [3:0]   WA3E;
    logic         PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE;
    logic [3:0]   Flags;
    logic         CondExE, BranchTakenE;
    logic         PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
    logic [N-1:0] ALUResultM, WriteDataM;
    logic [3:0]   WA3M;

    int nCompared = 0;
    int nMismatch = 0;
    bit checkEn   = 0;

    logic [3:0]   expFlags;
    logic         expPCSrcM, expRegWriteM, expMemWriteM, expMemtoRegM;
    logic [N-1:0] expALUResultM, expWriteDataM;
    logic [3:0]   expWA3M;

    exe_cond_stage #(.N(N)) dut (
        .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .AluFlags(AluFlags),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .BranchE(BranchE),
        .Flags(Flags), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .WA3M(WA3M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM encoding: bits [3:1] pick a base test, bit 0 inverts it.
    function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic checkVal(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelUpdate();
        logic pass;
        pass = condPass(CondE, expFlags);
        if (reset) begin
            expFlags = 4'b0; expPCSrcM = 0; expRegWriteM = 0; expMemWriteM = 0;
            expMemtoRegM = 0; expALUResultM = '0; expWriteDataM = '0; expWA3M = 4'b0;
        end else if (FlushM) begin
            expPCSrcM = 0; expRegWriteM = 0; expMemWriteM = 0; expMemtoRegM = 0;
            expALUResultM = '0; expWriteDataM = '0; expWA3M = 4'b0;
        end else if (!StallM) begin
            expPCSrcM     = PCSrcE && pass;
            expRegWriteM  = RegWriteE && pass;
            expMemWriteM  = MemWriteE && pass;
            expMemtoRegM  = MemtoRegE;
            expALUResultM = ALUResultE;
            expWriteDataM = WriteDataE;
            expWA3M       = WA3E;
            if (pass && FlagWriteE[1]) expFlags[3:2] = AluFlags[3:2];
            if (pass && FlagWriteE[0]) expFlags[1:0] = AluFlags[1:0];
        end
    endtask

    task automatic checkOutput();
        logic pass;
        pass = condPass(CondE, expFlags);
        checkVal("Flags", N'(Flags), N'(expFlags));
        checkVal("CondExE", N'(CondExE), N'(pass));
        checkVal("BranchTakenE", N'(BranchTakenE), N'(BranchE && pass));
        checkVal("PCSrcM", N'(PCSrcM), N'(expPCSrcM));
        checkVal("RegWriteM", N'(RegWriteM), N'(expRegWriteM));
        checkVal("MemWriteM", N'(MemWriteM), N'(expMemWriteM));
        checkVal("MemtoRegM", N'(MemtoRegM), N'(expMemtoRegM));
        checkVal("ALUResultM", ALUResultM, expALUResultM);
        checkVal("WriteDataM", WriteDataM, expWriteDataM);
        checkVal("WA3M", N'(WA3M), N'(expWA3M));
    endtask

    // Single compare process: inputs settle at the falling edge, checked just after.
    always @(negedge clk) begin
        #2;
        if (checkEn) checkOutput();
    end

    task automatic setIdle();
        reset = 0; StallM = 0; FlushM = 0; CondE = 4'b1110; FlagWriteE = 2'b00;
        AluFlags = 4'b0; ALUResultE = '0; WriteDataE = '0; WA3E = 4'b0;
        PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; BranchE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        reset      = ($urandom_range(0, 49) == 0);
        StallM     = ($urandom_range(0, 4) == 0);
        FlushM     = ($urandom_range(0, 7) == 0);
        CondE      = 4'($urandom_range(0, 15));
        FlagWriteE = 2'($urandom_range(0, 3));
        AluFlags   = 4'($urandom_range(0, 15));
        ALUResultE = $urandom;
        WriteDataE = $urandom;
        WA3E       = 4'($urandom_range(0, 15));
        PCSrcE     = 1'($urandom_range(0, 1));
        RegWriteE  = 1'($urandom_range(0, 1));
        MemWriteE  = 1'($urandom_range(0, 1));
        MemtoRegE  = 1'($urandom_range(0, 1));
        BranchE    = 1'($urandom_range(0, 1));
    endtask

    initial begin
        setIdle();
        reset = 1;
        tick();
        checkEn = 1;
        tick();
        checkVal("reset Flags", N'(Flags), N'(4'b0000));
        checkVal("reset RegWriteM", N'(RegWriteM), N'(1'b0));
        CondE = 4'b0001;
        #1 checkVal("reset NE CondExE", N'(CondExE), N'(1'b1));
        tick();

        setIdle();
        CondE = 4'b1110; FlagWriteE = 2'b11; AluFlags = 4'b0100; RegWriteE = 1; ALUResultE = 32'h5;
        tick();
        setIdle();
        checkVal("load Flags", N'(Flags), N'(4'b0100));
        checkVal("load RegWriteM", N'(RegWriteM), N'(1'b1));
        checkVal("load ALUResultM", ALUResultM, 32'h5);

        CondE = 4'b0001; RegWriteE = 1; MemWriteE = 1; FlagWriteE = 2'b11; AluFlags = 4'b1000;
        #1 checkVal("NE fail CondExE", N'(CondExE), N'(1'b0));
        tick();
        setIdle();
        checkVal("NE fail RegWriteM", N'(RegWriteM), N'(1'b0));
        checkVal("NE fail MemWriteM", N'(MemWriteM), N'(1'b0));
        checkVal("NE fail Flags", N'(Flags), N'(4'b0100));

        FlagWriteE = 2'b11; AluFlags = 4'b0000;
        tick();
        FlagWriteE = 2'b10; AluFlags = 4'b1111;
        tick();
        checkVal("NZ-only Flags", N'(Flags), N'(4'b1100));
        FlagWriteE = 2'b01; AluFlags = 4'b0011;
        tick();
        setIdle();
        checkVal("CV-only Flags", N'(Flags), N'(4'b1111));

        StallM = 1; FlushM = 1; RegWriteE = 1; FlagWriteE = 2'b11; ALUResultE = 32'h77;
        tick();
        setIdle();
        checkVal("flush+stall RegWriteM", N'(RegWriteM), N'(1'b0));
        checkVal("flush+stall ALUResultM", ALUResultM, 32'h0);
        checkVal("flush+stall Flags", N'(Flags), N'(4'b1111));

        RegWriteE = 1; ALUResultE = 32'h1234; WA3E = 4'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            StallM = 1; FlagWriteE = 2'b11; AluFlags = 4'(i);
            ALUResultE = 32'(100 + i); WA3E = 4'(8 + i);
            tick();
            checkVal("stall ALUResultM", ALUResultM, 32'h1234);
            checkVal("stall WA3M", N'(WA3M), N'(4'd3));
            checkVal("stall Flags", N'(Flags), N'(4'b1111));
        end
        setIdle();
        ALUResultE = 32'h99; WA3E = 4'd9;
        tick();
        setIdle();
        checkVal("release ALUResultM", ALUResultM, 32'h99);
        checkVal("release WA3M", N'(WA3M), N'(4'd9));

        FlagWriteE = 2'b11; AluFlags = 4'b1001;
        tick();
        setIdle();
        CondE = 4'b1010;
        #1 checkVal("GE CondExE", N'(CondExE), N'(1'b1));
        BranchE = 1;
        #1 checkVal("GE BranchTakenE", N'(BranchTakenE), N'(1'b1));
        CondE = 4'b1101;
        #1 checkVal("LE CondExE", N'(CondExE), N'(1'b0));
        CondE = 4'b1111;
        #1 checkVal("NV CondExE", N'(CondExE), N'(1'b0));
        setIdle();

        RegWriteE = 1; ALUResultE = 32'hABCD;
        tick();
        reset = 1; StallM = 1; FlushM = 0;
        tick();
        setIdle();
        checkVal("midreset Flags", N'(Flags), N'(4'b0000));
        checkVal("midreset RegWriteM", N'(RegWriteM), N'(1'b0));
        checkVal("midreset ALUResultM", ALUResultM, 32'h0);

        for (int i = 0; i < 600; i++) begin
            applyStimulus();
            tick();
        end
        setIdle();
        tick();
        checkEn = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/exe_cond_stage.md
EXE_COND_STAGE -- requirements
Module: exe_cond_stage

Interface
REQ-001 Parameter: N, default 32, datapath width (matches the ALU's N).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 StallM  input  1  hold M-stage register and flags this cycle.
REQ-005 FlushM  input  1  load bubble into M-stage register this cycle.
REQ-006 CondE  input  4  ARM condition field of the E-stage instruction.
REQ-007 FlagWriteE  input  2  bit1 = update N,Z; bit0 = update C,V.
REQ-008 AluFlags  input  4  ALU flags {N,Z,C,V} of the E-stage instruction.
REQ-009 ALUResultE, WriteDataE  input  N each  ALU result and store data.
REQ-010 WA3E  input  4  destination register index.
REQ-011 PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE  input  1 each  decoded E-stage controls.
REQ-012 Flags  output  4  architectural {N,Z,C,V} register.
REQ-013 CondExE  output  1  condition passed (combinational).
REQ-014 BranchTakenE  output  1  BranchE & CondExE (combinational).
REQ-015 PCSrcM, RegWriteM, MemWriteM, MemtoRegM  output  1 each  gated, registered controls.
REQ-016 ALUResultM, WriteDataM  output  N each; WA3M  output  4  registered data.

Function
REQ-017 CondExE SHALL evaluate CondE against the registered Flags (never same-cycle AluFlags): 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-018 Flags[3:2] SHALL load AluFlags[3:2] on a clk edge only when FlagWriteE[1] & CondExE & ~StallM & ~FlushM & ~reset.
REQ-019 Flags[1:0] SHALL load AluFlags[1:0] under the same rule using FlagWriteE[0]; the two halves update independently.
REQ-020 An instruction whose CondExE=0 SHALL not modify Flags.
REQ-021 Gated controls: PCSrc = PCSrcE&CondExE, RegWrite = RegWriteE&CondExE, MemWrite = MemWriteE&CondExE; MemtoReg and data SHALL pass ungated.
REQ-022 M-stage register latency SHALL be exactly one cycle: values present in cycle t appear on *M outputs in cycle t+1.
REQ-023 StallM=1 (FlushM=0) SHALL hold every M-stage output and Flags unchanged.
REQ-024 FlushM=1 SHALL load PCSrcM, RegWriteM, MemWriteM, MemtoRegM with 0 and ALUResultM, WriteDataM, WA3M with 0, regardless of StallM (flush wins over stall).
REQ-025 Priority at a clk edge SHALL be reset > FlushM > StallM > normal load.
REQ-026 A flag-setting instruction followed immediately by a conditional instruction SHALL see the updated Flags (register-to-next-cycle path, no bypass needed).
REQ-027 Block SHALL contain no latches; all outputs SHALL be known (non-X) after the first reset edge.

Reset
REQ-028 reset=1 at a clk edge SHALL set Flags=4'b0000 and all *M outputs to 0.
REQ-029 reset asserted mid-operation SHALL override StallM and FlushM in that cycle.
REQ-030 While reset is held, CondExE SHALL still be driven combinationally from Flags=0000 (e.g. CondE=0001 -> 1).

Verification
REQ-031 Reset, then CondE=1110, FlagWriteE=11, AluFlags=0100, RegWriteE=1, ALUResultE=32'h5 -> next cycle Flags=0100, RegWriteM=1, ALUResultM=5.
REQ-032 Flags=0100, CondE=0001 (NE), RegWriteE=1, MemWriteE=1, FlagWriteE=11, AluFlags=1000 -> CondExE=0, RegWriteM=0, MemWriteM=0, Flags stays 0100.
REQ-033 Flags=0000, FlagWriteE=10, AluFlags=1111 with CondE=1110 -> Flags=1100 (C,V untouched); then FlagWriteE=01, AluFlags=0011 -> Flags=1111.
REQ-034 StallM=1 and FlushM=1 together with RegWriteE=1, CondE=1110, FlagWriteE=11 -> RegWriteM=0, ALUResultM=0, Flags unchanged.
REQ-035 StallM=1 for 3 cycles with changing E inputs -> *M outputs and Flags constant; release -> next E values captured after one edge.
REQ-036 Flags=1001 (N=1,V=1): CondE=1010 (GE) -> CondExE=1; CondE=1101 (LE) -> 0; CondE=1111 -> 0; BranchE=1 with GE -> BranchTakenE=1.
